// File: rtl/dmem_bus_arbiter_pkg.sv
// dmem_bus_arbiter_pkg
//   Shared definitions for the data-memory bus arbiter and its neighbours
//   (cpu, DMA controller). Holds the arbiter state encoding and the bus
//   geometry constants, so every block agrees on the address width and on
//   the number of words in one DMA block write.
package dmem_bus_arbiter_pkg;

  localparam int DMEM_WORD_SIZE   = 16;  // address width of the data bus
  localparam int DMEM_BLOCK_WORDS = 4;   // words moved by one DMA block write
  localparam int DMEM_MAX_HOLD    = 8;   // grant cycles before a waiting CPU may preempt

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // CPU owns the bus, no DMA request
    DRAIN = 2'd1,  // DMA waiting for the in-flight CPU access to finish
    GRANT = 2'd2,  // DMA owns the bus
    YIELD = 2'd3   // DMA preempted so one CPU access can complete
  } arb_state_t;

endpackage

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter
//   Arbitrates the data-memory port between the CPU (default owner) and the
//   DMA controller using a BR/BG handshake. A DMA request waits for any CPU
//   access in flight, then the DMA block-write address/strobe is muxed onto
//   the memory port. A saturating hold counter lets a waiting CPU take the
//   bus back for one access at a block boundary, so it is never starved.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   cpu_readM/cpu_writeM  CPU data request, held until mem_ready
//   cpu_address           CPU data address
//   BR                    DMA bus request
//   dma_WRITE             DMA block-write strobe, held until mem_ready
//   dma_addr, dma_offset  DMA base address and block index
//   mem_ready             memory completes the current access this cycle
//   BG                    registered bus grant
//   d_readM/d_writeM      memory read / write
//   d_address             memory address
//   dsel                  1 = DMA drives the data bus
//   cpu_stall             CPU must hold its request (bus belongs to DMA)
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = DMEM_WORD_SIZE,
  parameter int BLOCK_WORDS = DMEM_BLOCK_WORDS,
  parameter int MAX_HOLD    = DMEM_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_readM,
  input  logic                 cpu_writeM,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic                 BR,
  input  logic                 dma_WRITE,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [1:0]           dma_offset,
  input  logic                 mem_ready,
  output logic                 BG,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic                 dsel,
  output logic                 cpu_stall
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]    HOLD_MAX    = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_THRESH = HOLD_W'(MAX_HOLD - 1);
  localparam logic [WORD_SIZE-1:0] BLOCK_STEP  = WORD_SIZE'(BLOCK_WORDS);

  arb_state_t          state_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic                bg_reg;

  logic                cpu_req;
  logic                cpu_done;
  logic                block_boundary;
  logic [WORD_SIZE-1:0] dma_block_addr;

  assign cpu_req  = cpu_readM | cpu_writeM;
  // The CPU no longer needs the bus once its access completes or it has none.
  assign cpu_done = !cpu_req || mem_ready;
  // A DMA block write ends on the cycle memory accepts it; only there may the
  // CPU take the bus back, so a block is never cut in half.
  assign block_boundary = dma_WRITE && mem_ready;

  // Offset is a block index; the sum wraps modulo 2^WORD_SIZE.
  assign dma_block_addr = dma_addr + ({{(WORD_SIZE-2){1'b0}}, dma_offset} * BLOCK_STEP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      bg_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (BR) begin
            if (cpu_req) begin
              // Simultaneous request: the CPU access goes first.
              state_reg <= DRAIN;
            end else begin
              state_reg    <= GRANT;
              bg_reg       <= 1'b1;
              hold_cnt_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (!BR) begin
            state_reg <= IDLE;
          end else if (cpu_done) begin
            state_reg    <= GRANT;
            bg_reg       <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
          if (!BR) begin
            state_reg <= IDLE;
            bg_reg    <= 1'b0;
          end else if (cpu_req && (hold_cnt_reg >= HOLD_THRESH) && block_boundary) begin
            state_reg <= YIELD;
            bg_reg    <= 1'b0;
          end
        end
        YIELD: begin
          if (!BR) begin
            state_reg <= IDLE;
          end else if (cpu_done) begin
            state_reg    <= GRANT;
            bg_reg       <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          bg_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign BG = bg_reg;

  // Owner is taken from the registered state only, so the port mux cannot
  // switch owners mid-cycle. Strobes are held low while reset is asserted.
  always_comb begin
    d_readM   = 1'b0;
    d_writeM  = 1'b0;
    d_address = cpu_address;
    dsel      = 1'b0;
    cpu_stall = 1'b0;
    if (state_reg == GRANT) begin
      d_address = dma_block_addr;
      d_writeM  = dma_WRITE && reset_n;
      dsel      = reset_n;
      cpu_stall = cpu_req && reset_n;
    end else begin
      d_readM  = cpu_readM && reset_n;
      d_writeM = cpu_writeM && reset_n;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter
//   Directed, table-driven bench for dmem_bus_arbiter. Each record holds the
//   inputs for one clock cycle and the outputs expected during that cycle.
//   Inputs are driven just after the rising edge, outputs checked on the
//   falling edge. A table covers reset, idle grant/release, address
//   arithmetic, drain, simultaneous request and BR drop in DRAIN; hand-built
//   sequences cover starvation preemption and reset during a grant.
module tb_dmem_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_readM;
  logic        cpu_writeM;
  logic [15:0] cpu_address;
  logic        BR;
  logic        dma_WRITE;
  logic [15:0] dma_addr;
  logic [1:0]  dma_offset;
  logic        mem_ready;
  logic        BG;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic        dsel;
  logic        cpu_stall;

  int n_vec;
  int n_miss;

  typedef struct packed {
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [15:0] caddr;
    logic        br;
    logic        dw;
    logic [15:0] daddr;
    logic [1:0]  doff;
    logic        rdy;
    logic        e_bg;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic        e_dsel;
    logic        e_stall;
  } vec_t;

  localparam int NTBL = 25;
  vec_t tbl [NTBL];

  dmem_bus_arbiter #(
    .WORD_SIZE  (16),
    .BLOCK_WORDS(4),
    .MAX_HOLD   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_readM  (cpu_readM),
    .cpu_writeM (cpu_writeM),
    .cpu_address(cpu_address),
    .BR         (BR),
    .dma_WRITE  (dma_WRITE),
    .dma_addr   (dma_addr),
    .dma_offset (dma_offset),
    .mem_ready  (mem_ready),
    .BG         (BG),
    .d_readM    (d_readM),
    .d_writeM   (d_writeM),
    .d_address  (d_address),
    .dsel       (dsel),
    .cpu_stall  (cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(
    input logic rst_n, input logic rd, input logic wr, input logic [15:0] caddr,
    input logic br, input logic dw, input logic [15:0] daddr, input logic [1:0] doff,
    input logic rdy,
    input logic e_bg, input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
    input logic e_dsel, input logic e_stall);
    vec_t r;
    r.rst_n = rst_n;  r.rd = rd;   r.wr = wr;     r.caddr = caddr;
    r.br = br;        r.dw = dw;   r.daddr = daddr; r.doff = doff;
    r.rdy = rdy;
    r.e_bg = e_bg;    r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr;
    r.e_dsel = e_dsel; r.e_stall = e_stall;
    return r;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge.
  task automatic apply(input vec_t x, input string name);
    logic [20:0] act;
    logic [20:0] exp;
    reset_n     = x.rst_n;
    cpu_readM   = x.rd;
    cpu_writeM  = x.wr;
    cpu_address = x.caddr;
    BR          = x.br;
    dma_WRITE   = x.dw;
    dma_addr    = x.daddr;
    dma_offset  = x.doff;
    mem_ready   = x.rdy;
    @(negedge clk);
    act = {BG, d_readM, d_writeM, d_address, dsel, cpu_stall};
    exp = {x.e_bg, x.e_rd, x.e_wr, x.e_addr, x.e_dsel, x.e_stall};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: {bg,rd,wr,addr,dsel,stall} got %b %b %b %h %b %b want %b %b %b %h %b %b",
               name, BG, d_readM, d_writeM, d_address, dsel, cpu_stall,
               x.e_bg, x.e_rd, x.e_wr, x.e_addr, x.e_dsel, x.e_stall);
    end else begin
      $display("ok   %s: bg=%b rd=%b wr=%b addr=%h dsel=%b stall=%b",
               name, BG, d_readM, d_writeM, d_address, dsel, cpu_stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //              rst rd wr caddr     br dw daddr     off rdy | bg rd wr addr      ds st
    // reset, CPU read strobe must be forced low
    tbl[0]  = v(0, 1, 0, 16'h1234, 1, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h1234, 0, 0);
    tbl[1]  = v(1, 0, 0, 16'h0100, 0, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0100, 0, 0);
    // idle grant: BR sampled here, BG next edge
    tbl[2]  = v(1, 0, 0, 16'h0100, 1, 0, 16'h0000, 0, 0,   0, 0, 0, 16'h0100, 0, 0);
    // GRANT: address arithmetic 0x01F4 + off*4, and wrap
    tbl[3]  = v(1, 0, 0, 16'h0100, 1, 1, 16'h01F4, 0, 0,   1, 0, 1, 16'h01F4, 1, 0);
    tbl[4]  = v(1, 0, 0, 16'h0100, 1, 1, 16'h01F4, 1, 1,   1, 0, 1, 16'h01F8, 1, 0);
    tbl[5]  = v(1, 0, 0, 16'h0100, 1, 1, 16'h01F4, 2, 1,   1, 0, 1, 16'h01FC, 1, 0);
    tbl[6]  = v(1, 0, 0, 16'h0100, 1, 1, 16'hFFFE, 1, 1,   1, 0, 1, 16'h0002, 1, 0);
    // CPU read while DMA owns bus: stalled, read not forwarded
    tbl[7]  = v(1, 1, 0, 16'h0200, 1, 0, 16'h0000, 3, 0,   1, 0, 0, 16'h000C, 1, 1);
    // release: BR low, BG drops on next edge
    tbl[8]  = v(1, 0, 0, 16'h0200, 0, 0, 16'h0000, 3, 0,   1, 0, 0, 16'h000C, 1, 0);
    tbl[9]  = v(1, 1, 0, 16'h0200, 0, 0, 16'h0000, 3, 0,   0, 1, 0, 16'h0200, 0, 0);
    // drain: read in flight, BG waits for mem_ready
    tbl[10] = v(1, 1, 0, 16'h0200, 1, 0, 16'h0300, 0, 0,   0, 1, 0, 16'h0200, 0, 0);
    tbl[11] = v(1, 1, 0, 16'h0200, 1, 0, 16'h0300, 0, 0,   0, 1, 0, 16'h0200, 0, 0);
    tbl[12] = v(1, 1, 0, 16'h0200, 1, 0, 16'h0300, 0, 1,   0, 1, 0, 16'h0200, 0, 0);
    tbl[13] = v(1, 0, 0, 16'h0200, 1, 0, 16'h0300, 0, 0,   1, 0, 0, 16'h0300, 1, 0);
    tbl[14] = v(1, 0, 0, 16'h0200, 0, 0, 16'h0300, 0, 0,   1, 0, 0, 16'h0300, 1, 0);
    tbl[15] = v(1, 0, 0, 16'h0200, 0, 0, 16'h0300, 0, 0,   0, 0, 0, 16'h0200, 0, 0);
    // simultaneous BR and CPU write: CPU first
    tbl[16] = v(1, 0, 1, 16'h0400, 1, 0, 16'h0500, 0, 0,   0, 0, 1, 16'h0400, 0, 0);
    tbl[17] = v(1, 0, 1, 16'h0400, 1, 0, 16'h0500, 0, 1,   0, 0, 1, 16'h0400, 0, 0);
    tbl[18] = v(1, 0, 0, 16'h0400, 1, 1, 16'h0500, 0, 0,   1, 0, 1, 16'h0500, 1, 0);
    tbl[19] = v(1, 0, 0, 16'h0400, 0, 0, 16'h0500, 0, 0,   1, 0, 0, 16'h0500, 1, 0);
    tbl[20] = v(1, 0, 0, 16'h0400, 0, 0, 16'h0500, 0, 0,   0, 0, 0, 16'h0400, 0, 0);
    // BR dropped during DRAIN: back to IDLE, no BG pulse
    tbl[21] = v(1, 1, 0, 16'h0600, 1, 0, 16'h0500, 0, 0,   0, 1, 0, 16'h0600, 0, 0);
    tbl[22] = v(1, 1, 0, 16'h0600, 0, 0, 16'h0500, 0, 0,   0, 1, 0, 16'h0600, 0, 0);
    tbl[23] = v(1, 1, 0, 16'h0600, 0, 0, 16'h0500, 0, 1,   0, 1, 0, 16'h0600, 0, 0);
    tbl[24] = v(1, 0, 0, 16'h0600, 0, 0, 16'h0500, 0, 0,   0, 0, 0, 16'h0600, 0, 0);

    // Bring state out of X before the first checked vector.
    reset_n = 1'b0; cpu_readM = 1'b0; cpu_writeM = 1'b0; cpu_address = '0;
    BR = 1'b0; dma_WRITE = 1'b0; dma_addr = '0; dma_offset = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NTBL; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Starvation: BR held, DMA writes with mem_ready on every third cycle,
    // CPU write pending from grant cycle 2. Preemption only at the first
    // block boundary with hold_cnt >= 7, i.e. grant cycle 8.
    apply(v(1, 0, 0, 16'h2000, 1, 0, 16'h1000, 0, 0,   0, 0, 0, 16'h2000, 0, 0), "starve_req");
    for (int k = 0; k <= 8; k++) begin
      logic pend;
      logic rdy;
      pend = (k >= 2);
      rdy  = ((k % 3) == 2);
      apply(v(1, 0, pend, 16'h2000, 1, 1, 16'h1000, 0, rdy,   1, 0, 1, 16'h1000, 1, pend),
            $sformatf("starve_grant%0d", k));
    end
    apply(v(1, 0, 1, 16'h2000, 1, 0, 16'h1000, 0, 0,   0, 0, 1, 16'h2000, 0, 0), "yield_wait");
    apply(v(1, 0, 1, 16'h2000, 1, 0, 16'h1000, 0, 1,   0, 0, 1, 16'h2000, 0, 0), "yield_done");
    // Regranted with hold_cnt cleared: boundary with CPU pending must not yield yet.
    apply(v(1, 0, 1, 16'h2000, 1, 1, 16'h1000, 0, 1,   1, 0, 1, 16'h1000, 1, 1), "regrant0");
    apply(v(1, 0, 1, 16'h2000, 1, 1, 16'h1000, 0, 1,   1, 0, 1, 16'h1000, 1, 1), "regrant1");

    // Reset during GRANT: strobes forced low at once, BG drops at the edge.
    apply(v(0, 0, 0, 16'h2000, 1, 1, 16'h1000, 0, 0,   1, 0, 0, 16'h1000, 0, 0), "rst_in_grant");
    apply(v(0, 0, 0, 16'h2000, 1, 1, 16'h1000, 0, 0,   0, 0, 0, 16'h2000, 0, 0), "rst_held");
    apply(v(1, 0, 0, 16'h2000, 1, 0, 16'h1000, 0, 0,   0, 0, 0, 16'h2000, 0, 0), "rst_release");
    apply(v(1, 0, 0, 16'h2000, 1, 0, 16'h1000, 0, 0,   1, 0, 0, 16'h1000, 1, 0), "rst_regrant");
    apply(v(1, 0, 0, 16'h2000, 0, 0, 16'h1000, 0, 0,   1, 0, 0, 16'h1000, 1, 0), "final_release");
    apply(v(1, 0, 0, 16'h2000, 0, 0, 16'h1000, 0, 0,   0, 0, 0, 16'h2000, 0, 0), "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
